// File: rtl/fpu_pkg.sv
// Shared FP issue-control definitions: opcodes, funct5 codes, FPU select codes,
// latency classes and the dynamic rounding-mode marker.
package fpu_pkg;

  localparam logic [6:0] OP_FP  = 7'b1010011;
  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_FSW = 7'b0100111;

  localparam logic [4:0] F5_ADD    = 5'b00000;
  localparam logic [4:0] F5_SUB    = 5'b00001;
  localparam logic [4:0] F5_MUL    = 5'b00010;
  localparam logic [4:0] F5_DIV    = 5'b00011;
  localparam logic [4:0] F5_SQRT   = 5'b01011;
  localparam logic [4:0] F5_SGNJ   = 5'b00100;
  localparam logic [4:0] F5_MINMAX = 5'b00101;
  localparam logic [4:0] F5_CMP    = 5'b10100;
  localparam logic [4:0] F5_CVT_WS = 5'b11000;
  localparam logic [4:0] F5_CVT_SW = 5'b11010;
  localparam logic [4:0] F5_MV_XW  = 5'b11100;
  localparam logic [4:0] F5_MV_WX  = 5'b11110;

  localparam logic [4:0] SEL_FADD    = 5'd1;
  localparam logic [4:0] SEL_FSUB    = 5'd2;
  localparam logic [4:0] SEL_FMUL    = 5'd3;
  localparam logic [4:0] SEL_FDIV    = 5'd4;
  localparam logic [4:0] SEL_FSQRT   = 5'd5;
  localparam logic [4:0] SEL_FSGNJ   = 5'd6;
  localparam logic [4:0] SEL_FMINMAX = 5'd7;
  localparam logic [4:0] SEL_FCMP    = 5'd8;
  localparam logic [4:0] SEL_FCVT_WS = 5'd9;
  localparam logic [4:0] SEL_FCVT_SW = 5'd10;
  localparam logic [4:0] SEL_FMV_XW  = 5'd11;
  localparam logic [4:0] SEL_FMV_WX  = 5'd12;

  localparam logic [2:0] RM_DYN = 3'b111;

  typedef enum logic [2:0] {CLS_ADD, CLS_MUL, CLS_DIV, CLS_SQRT, CLS_MISC} fpu_cls_e;

  // Rounding modes 101..111 are reserved once dynamic selection is resolved.
  function automatic logic rm_valid(input logic [2:0] rm);
    return rm < 3'b101;
  endfunction

endpackage

// File: rtl/fpu_op_classify.sv
// Combinational OP-FP decode: latency class, FPU select, operand/destination
// register-file sides, resolved rounding mode and illegal detection.
module fpu_op_classify
  import fpu_pkg::*;
(
  input  logic [4:0] funct5_i,
  input  logic [2:0] rm_i,
  input  logic [2:0] frm_i,
  output fpu_cls_e   cls_o,
  output logic [4:0] sel_o,
  output logic       rs1_int_o,
  output logic       rs2_fp_o,
  output logic       dest_int_o,
  output logic [2:0] rm_o,
  output logic       illegal_o
);

  logic bad_f5;

  assign rm_o      = (rm_i == RM_DYN) ? frm_i : rm_i;
  assign illegal_o = bad_f5 || !rm_valid(rm_o);

  // funct5 lookup: class, select code and which register file each operand uses
  always_comb begin
    cls_o      = CLS_MISC;
    sel_o      = '0;
    rs1_int_o  = 1'b0;
    rs2_fp_o   = 1'b0;
    dest_int_o = 1'b0;
    bad_f5     = 1'b0;
    case (funct5_i)
      F5_ADD:    begin cls_o = CLS_ADD;  sel_o = SEL_FADD;    rs2_fp_o = 1'b1; end
      F5_SUB:    begin cls_o = CLS_ADD;  sel_o = SEL_FSUB;    rs2_fp_o = 1'b1; end
      F5_MUL:    begin cls_o = CLS_MUL;  sel_o = SEL_FMUL;    rs2_fp_o = 1'b1; end
      F5_DIV:    begin cls_o = CLS_DIV;  sel_o = SEL_FDIV;    rs2_fp_o = 1'b1; end
      F5_SQRT:   begin cls_o = CLS_SQRT; sel_o = SEL_FSQRT;   end
      F5_SGNJ:   begin sel_o = SEL_FSGNJ;   rs2_fp_o = 1'b1; end
      F5_MINMAX: begin sel_o = SEL_FMINMAX; rs2_fp_o = 1'b1; end
      F5_CMP:    begin sel_o = SEL_FCMP;    rs2_fp_o = 1'b1; dest_int_o = 1'b1; end
      F5_CVT_WS: begin sel_o = SEL_FCVT_WS; dest_int_o = 1'b1; end
      F5_CVT_SW: begin sel_o = SEL_FCVT_SW; rs1_int_o = 1'b1; end
      F5_MV_XW:  begin sel_o = SEL_FMV_XW;  dest_int_o = 1'b1; end
      F5_MV_WX:  begin sel_o = SEL_FMV_WX;  rs1_int_o = 1'b1; end
      default:   bad_f5 = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue control: accepts decoded instructions, issues one FP op at a time to
// a multi-cycle FPU, tracks its destination and stalls decode on hazards.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_MISC = 1,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [6:0] in_op,
  input  logic [4:0] in_funct5,
  input  logic [2:0] in_rm,
  input  logic [4:0] in_rd,
  input  logic [4:0] in_rs1,
  input  logic [4:0] in_rs2,
  input  logic       in_uses_rs1,
  input  logic       in_uses_rs2,
  input  logic [2:0] frm,
  input  logic       flush,
  output logic       in_ready,
  output logic       illegal,
  output logic       fpu_start,
  output logic [4:0] selFPU,
  output logic       FPUAinSel,
  output logic [2:0] fpu_rm,
  output logic       busy,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       RegWriteF,
  output logic       RegWriteI
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             pend_v_q, pend_v_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_isint_q, pend_isint_d;
  logic [4:0]       sel_q, sel_d;
  logic             ain_q, ain_d;
  logic [2:0]       rm_q, rm_d;

  fpu_cls_e   cls;
  logic [4:0] cls_sel;
  logic       rs1_int, rs2_fp, dest_int, cls_illegal;
  logic [2:0] rm_res;
  logic [CNT_W-1:0] lat;

  fpu_op_classify u_classify (
    .funct5_i   (in_funct5),
    .rm_i       (in_rm),
    .frm_i      (frm),
    .cls_o      (cls),
    .sel_o      (cls_sel),
    .rs1_int_o  (rs1_int),
    .rs2_fp_o   (rs2_fp),
    .dest_int_o (dest_int),
    .rm_o       (rm_res),
    .illegal_o  (cls_illegal)
  );

  logic is_opfp, is_flw, is_fsw;
  assign is_opfp = (in_op == OP_FP);
  assign is_flw  = (in_op == OP_FLW);
  assign is_fsw  = (in_op == OP_FSW);

  assign busy      = (state_q == S_EXEC);
  assign wb_valid  = busy && (cnt_q == CNT_W'(1));
  assign RegWriteF = wb_valid && !pend_isint_q;
  assign RegWriteI = wb_valid && pend_isint_q;
  assign fpu_start = start_q;
  assign selFPU    = sel_q;
  assign FPUAinSel = ain_q;
  assign fpu_rm    = rm_q;
  assign wb_rd     = pend_rd_q;

  // x0 as an integer destination never creates a dependency.
  logic fp_pend, int_pend;
  assign fp_pend  = pend_v_q && !pend_isint_q;
  assign int_pend = pend_v_q && pend_isint_q && (pend_rd_q != '0);

  logic hit_rs1, hit_rs2, hit_rd;
  assign hit_rs1 = (in_rs1 == pend_rd_q);
  assign hit_rs2 = (in_rs2 == pend_rd_q);
  assign hit_rd  = (in_rd  == pend_rd_q);

  logic hazard, accept;

  // Hazard detection for the instruction in decode; the scoreboard still blocks during the wb cycle
  always_comb begin
    hazard = 1'b0;
    if (is_opfp) begin
      hazard = (busy && !wb_valid)
            || ( rs1_int && int_pend && hit_rs1)
            || (!rs1_int && fp_pend  && hit_rs1)
            || ( rs2_fp  && fp_pend  && hit_rs2)
            || (!dest_int && fp_pend && hit_rd);
    end else if (is_flw) begin
      hazard = (int_pend && hit_rs1) || (fp_pend && hit_rd);
    end else if (is_fsw) begin
      hazard = (int_pend && hit_rs1) || (fp_pend && hit_rs2);
    end else begin
      hazard = int_pend && ((in_uses_rs1 && hit_rs1) || (in_uses_rs2 && hit_rs2));
    end
  end

  // Illegal ops are consumed (ready) regardless of hazards so decode never deadlocks on them.
  assign illegal  = in_valid && is_opfp && cls_illegal;
  assign in_ready = !flush && (illegal || !hazard);
  assign accept   = in_valid && in_ready && is_opfp && !illegal;

  // Latency for the class being issued
  always_comb begin
    case (cls)
      CLS_ADD:  lat = CNT_W'(LAT_ADD);
      CLS_MUL:  lat = CNT_W'(LAT_MUL);
      CLS_DIV:  lat = CNT_W'(LAT_DIV);
      CLS_SQRT: lat = CNT_W'(LAT_SQRT);
      default:  lat = CNT_W'(LAT_MISC);
    endcase
  end

  // Next-state: countdown in EXEC, retire on wb, and a new issue (possibly back-to-back) overrides retire
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    pend_v_d     = pend_v_q;
    pend_rd_d    = pend_rd_q;
    pend_isint_d = pend_isint_q;
    sel_d        = sel_q;
    ain_d        = ain_q;
    rm_d         = rm_q;
    if (state_q == S_EXEC) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (wb_valid) begin
        state_d  = S_IDLE;
        pend_v_d = 1'b0;
      end
    end
    if (accept) begin
      state_d      = S_EXEC;
      cnt_d        = lat;
      start_d      = 1'b1;
      pend_v_d     = 1'b1;
      pend_rd_d    = in_rd;
      pend_isint_d = dest_int;
      sel_d        = cls_sel;
      ain_d        = rs1_int;
      rm_d         = rm_res;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_rd_q    <= '0;
      pend_isint_q <= 1'b0;
      sel_q        <= '0;
      ain_q        <= 1'b0;
      rm_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      pend_v_q     <= pend_v_d;
      pend_rd_q    <= pend_rd_d;
      pend_isint_q <= pend_isint_d;
      sel_q        <= sel_d;
      ain_q        <= ain_d;
      rm_q         <= rm_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: timestamp-based reference model checked every
// cycle, plus hand-computed pinned expectations on directed sequences.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int LAT_ADD  = 2;
  localparam int LAT_MUL  = 3;
  localparam int LAT_DIV  = 12;
  localparam int LAT_SQRT = 16;
  localparam int LAT_MISC = 1;
  localparam logic [6:0] OPI = 7'b0110011;

  localparam int W_RDY = 0, W_ILL = 1, W_START = 2, W_SEL = 3, W_AIN = 4, W_RM = 5,
                 W_BUSY = 6, W_WB = 7, W_WBRD = 8, W_RF = 9, W_RI = 10;

  logic clk = 1'b0;
  logic reset, in_valid, in_uses_rs1, in_uses_rs2, flush;
  logic [6:0] in_op;
  logic [4:0] in_funct5, in_rd, in_rs1, in_rs2;
  logic [2:0] in_rm, frm;
  logic in_ready, illegal, fpu_start, FPUAinSel, busy, wb_valid, RegWriteF, RegWriteI;
  logic [4:0] selFPU, wb_rd;
  logic [2:0] fpu_rm;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
                   .LAT_SQRT(LAT_SQRT), .LAT_MISC(LAT_MISC), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_funct5(in_funct5),
    .in_rm(in_rm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .frm(frm), .flush(flush),
    .in_ready(in_ready), .illegal(illegal), .fpu_start(fpu_start), .selFPU(selFPU),
    .FPUAinSel(FPUAinSel), .fpu_rm(fpu_rm), .busy(busy), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .RegWriteF(RegWriteF), .RegWriteI(RegWriteI)
  );

  typedef struct {int cyc; int what; logic [7:0] val; string nm;} pin_t;
  pin_t pins[$];

  int cyc, t0, total, bad;

  // ---------------- reference model (compare process only) ----------------
  bit         m_v, m_int;
  logic [4:0] m_rd;
  int         m_s, m_w;
  logic [4:0] h_sel, h_rd;
  bit         h_ain;
  logic [2:0] h_rm;

  bit ok, dint, r1int, r2fp, opfp, flw, fsw, e_ill, stall, e_rdy, e_wb, fpb, intb;
  int lat;
  logic [4:0] csel;
  logic [2:0] rmr;

  function automatic void spec_class(input logic [4:0] f5, output bit legal, output int l,
                                     output bit di, output bit r1, output bit r2,
                                     output logic [4:0] s);
    legal = 1; l = LAT_MISC; di = 0; r1 = 0; r2 = 0; s = 5'd0;
    case (f5)
      5'b00000: begin l = LAT_ADD;  r2 = 1; s = 5'd1; end
      5'b00001: begin l = LAT_ADD;  r2 = 1; s = 5'd2; end
      5'b00010: begin l = LAT_MUL;  r2 = 1; s = 5'd3; end
      5'b00011: begin l = LAT_DIV;  r2 = 1; s = 5'd4; end
      5'b01011: begin l = LAT_SQRT; s = 5'd5; end
      5'b00100: begin r2 = 1; s = 5'd6; end
      5'b00101: begin r2 = 1; s = 5'd7; end
      5'b10100: begin r2 = 1; di = 1; s = 5'd8; end
      5'b11000: begin di = 1; s = 5'd9; end
      5'b11010: begin r1 = 1; s = 5'd10; end
      5'b11100: begin di = 1; s = 5'd11; end
      5'b11110: begin r1 = 1; s = 5'd12; end
      default:  legal = 0;
    endcase
  endfunction

  function automatic logic [7:0] actual(input int what);
    case (what)
      W_RDY:   return {7'd0, in_ready};
      W_ILL:   return {7'd0, illegal};
      W_START: return {7'd0, fpu_start};
      W_SEL:   return {3'd0, selFPU};
      W_AIN:   return {7'd0, FPUAinSel};
      W_RM:    return {5'd0, fpu_rm};
      W_BUSY:  return {7'd0, busy};
      W_WB:    return {7'd0, wb_valid};
      W_WBRD:  return {3'd0, wb_rd};
      W_RF:    return {7'd0, RegWriteF};
      default: return {7'd0, RegWriteI};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    cyc = 0; total = 0; bad = 0;
    m_v = 0; m_int = 0; m_rd = 0; m_s = 0; m_w = 0;
    h_sel = 0; h_rd = 0; h_ain = 0; h_rm = 0;
    forever begin
      @(negedge clk);
      spec_class(in_funct5, ok, lat, dint, r1int, r2fp, csel);
      rmr   = (in_rm == 3'b111) ? frm : in_rm;
      opfp  = (in_op == 7'b1010011);
      flw   = (in_op == 7'b0000111);
      fsw   = (in_op == 7'b0100111);
      e_ill = in_valid && opfp && (!ok || rmr > 3'd4);
      fpb   = m_v && !m_int;
      intb  = m_v && m_int && m_rd != 5'd0;
      e_wb  = m_v && cyc == m_w;
      if (opfp)
        stall = (m_v && !e_wb)
             || (fpb && ((!r1int && in_rs1 == m_rd) || (r2fp && in_rs2 == m_rd)
                         || (!dint && in_rd == m_rd)))
             || (intb && r1int && in_rs1 == m_rd);
      else if (flw) stall = (fpb && in_rd == m_rd) || (intb && in_rs1 == m_rd);
      else if (fsw) stall = (fpb && in_rs2 == m_rd) || (intb && in_rs1 == m_rd);
      else stall = intb && ((in_uses_rs1 && in_rs1 == m_rd) || (in_uses_rs2 && in_rs2 == m_rd));
      e_rdy = !flush && (e_ill || !stall);

      chk("in_ready",  {7'd0, in_ready},  {7'd0, e_rdy});
      chk("illegal",   {7'd0, illegal},   {7'd0, e_ill});
      chk("fpu_start", {7'd0, fpu_start}, {7'd0, m_v && cyc == m_s});
      chk("selFPU",    {3'd0, selFPU},    {3'd0, h_sel});
      chk("FPUAinSel", {7'd0, FPUAinSel}, {7'd0, h_ain});
      chk("fpu_rm",    {5'd0, fpu_rm},    {5'd0, h_rm});
      chk("busy",      {7'd0, busy},      {7'd0, m_v});
      chk("wb_valid",  {7'd0, wb_valid},  {7'd0, e_wb});
      chk("wb_rd",     {3'd0, wb_rd},     {3'd0, h_rd});
      chk("RegWriteF", {7'd0, RegWriteF}, {7'd0, e_wb && !m_int});
      chk("RegWriteI", {7'd0, RegWriteI}, {7'd0, e_wb && m_int});

      foreach (pins[i])
        if (pins[i].cyc == cyc) chk(pins[i].nm, actual(pins[i].what), pins[i].val);

      if (reset) begin
        m_v = 0; h_sel = 0; h_rd = 0; h_ain = 0; h_rm = 0;
      end else begin
        if (e_wb) m_v = 0;
        if (in_valid && e_rdy && opfp && !e_ill) begin
          m_v = 1; m_s = cyc + 1; m_w = cyc + lat; m_rd = in_rd; m_int = dint;
          h_sel = csel; h_ain = r1int; h_rm = rmr; h_rd = in_rd;
        end
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [6:0] op, input logic [4:0] f5, input logic [2:0] rm,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2);
    in_valid = 1'b1; in_op = op; in_funct5 = f5; in_rm = rm;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_uses_rs1 = u1; in_uses_rs2 = u2;
  endtask

  task automatic nop();
    put(7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic pin(input int rel, input int what, input logic [7:0] v, input string nm);
    pins.push_back('{t0 + rel, what, v, nm});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; frm = 3'b000; nop();
    repeat (3) step();
    reset = 1'b0;

    // FDIV f3 alone
    step(); put(OP_FP, F5_DIV, 3'b000, 5'd3, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(0, W_RDY, 1, "div_accept");  pin(1, W_START, 1, "div_start");
    pin(1, W_SEL, 8'd4, "div_sel");  pin(1, W_BUSY, 1, "div_busy1");
    pin(2, W_START, 0, "div_start_pulse"); pin(11, W_WB, 0, "div_wb_early");
    pin(12, W_WB, 1, "div_wb");      pin(12, W_RF, 1, "div_rf");
    pin(12, W_RI, 0, "div_ri");      pin(12, W_WBRD, 3, "div_wbrd");
    pin(12, W_BUSY, 1, "div_busy12"); pin(13, W_BUSY, 0, "div_idle");
    step(); nop(); repeat (13) step();

    // FDIV f3 then dependent FADD f4,f3,f1
    step(); put(OP_FP, F5_DIV, 3'b000, 5'd3, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(1, W_RDY, 0, "raw_stall1"); pin(12, W_RDY, 0, "raw_stall_wb");
    pin(13, W_RDY, 1, "raw_accept"); pin(14, W_START, 1, "raw_start");
    pin(15, W_WB, 1, "raw_wb");     pin(15, W_WBRD, 4, "raw_wbrd");
    repeat (13) begin step(); put(OP_FP, F5_ADD, 3'b000, 5'd4, 5'd3, 5'd1, 0, 0); end
    step(); nop(); repeat (3) step();

    // FDIV f3 then independent FADD f4,f5,f6: back-to-back in wb cycle
    step(); put(OP_FP, F5_DIV, 3'b000, 5'd3, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(11, W_RDY, 0, "str_stall"); pin(12, W_RDY, 1, "str_accept_wb");
    pin(12, W_WB, 1, "str_div_wb"); pin(12, W_WBRD, 3, "str_div_wbrd");
    pin(13, W_START, 1, "b2b_start"); pin(13, W_BUSY, 1, "b2b_busy");
    pin(14, W_WB, 1, "b2b_wb");     pin(14, W_WBRD, 4, "b2b_wbrd");
    pin(15, W_BUSY, 0, "b2b_idle");
    repeat (12) begin step(); put(OP_FP, F5_ADD, 3'b000, 5'd4, 5'd5, 5'd6, 0, 0); end
    step(); nop(); repeat (3) step();

    // FCMP x5 then add x6,x5,x1; FCVT.W.S x0 then add x6,x0,x1
    step(); put(OP_FP, F5_CMP, 3'b010, 5'd5, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(1, W_START, 1, "cmp_start"); pin(1, W_WB, 1, "cmp_wb");
    pin(1, W_RI, 1, "cmp_ri");       pin(1, W_RF, 0, "cmp_rf");
    pin(1, W_WBRD, 5, "cmp_wbrd");   pin(1, W_RM, 8'd2, "cmp_rm");
    pin(1, W_SEL, 8'd8, "cmp_sel");  pin(1, W_RDY, 0, "int_stall");
    pin(2, W_RDY, 1, "int_release"); pin(3, W_RDY, 1, "cvt_accept");
    pin(4, W_RDY, 1, "x0_nostall");  pin(4, W_RI, 1, "cvt_ri");
    pin(4, W_WBRD, 0, "cvt_wbrd");
    repeat (2) begin step(); put(OPI, 5'd0, 3'd0, 5'd6, 5'd5, 5'd1, 1, 0); end
    step(); put(OP_FP, F5_CVT_WS, 3'b001, 5'd0, 5'd1, 5'd0, 0, 0);
    step(); put(OPI, 5'd0, 3'd0, 5'd6, 5'd0, 5'd1, 1, 0);
    step(); nop(); repeat (2) step();

    // Dynamic rm, invalid rm, reserved funct5, FMV.W.X int source
    step(); frm = 3'b010; put(OP_FP, F5_ADD, 3'b111, 5'd5, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(0, W_ILL, 0, "dyn_legal");   pin(1, W_RM, 8'd2, "dyn_rm");
    pin(1, W_START, 1, "dyn_start"); pin(2, W_WB, 1, "dyn_wb");
    pin(3, W_ILL, 1, "badrm_ill");   pin(3, W_RDY, 1, "badrm_ready");
    pin(4, W_START, 0, "badrm_nostart"); pin(4, W_BUSY, 0, "badrm_nobusy");
    pin(4, W_RM, 8'd2, "rm_held");   pin(4, W_ILL, 1, "badf5_ill");
    pin(5, W_START, 0, "badf5_nostart"); pin(5, W_ILL, 0, "mvwx_legal");
    pin(6, W_START, 1, "mvwx_start"); pin(6, W_AIN, 1, "mvwx_ain");
    pin(6, W_SEL, 8'd12, "mvwx_sel"); pin(6, W_RF, 1, "mvwx_rf");
    pin(6, W_WBRD, 2, "mvwx_wbrd");
    step(); nop(); step();
    step(); frm = 3'b101; put(OP_FP, F5_ADD, 3'b111, 5'd6, 5'd1, 5'd2, 0, 0);
    step(); frm = 3'b000; put(OP_FP, 5'b00110, 3'b000, 5'd6, 5'd1, 5'd2, 0, 0);
    step(); put(OP_FP, F5_MV_WX, 3'b000, 5'd2, 5'd7, 5'd0, 0, 0);
    step(); nop(); repeat (2) step();

    // FSQRT in flight while a flushed FADD waits in decode
    step(); put(OP_FP, F5_SQRT, 3'b000, 5'd7, 5'd8, 5'd0, 0, 0); t0 = cyc;
    pin(1, W_START, 1, "sqrt_start"); pin(1, W_SEL, 8'd5, "sqrt_sel");
    pin(2, W_RDY, 0, "flush_rdy");   pin(16, W_RDY, 0, "flush_rdy_wb");
    pin(16, W_WB, 1, "sqrt_wb");     pin(16, W_WBRD, 7, "sqrt_wbrd");
    pin(16, W_RF, 1, "sqrt_rf");     pin(17, W_BUSY, 0, "flush_nobusy");
    pin(17, W_START, 0, "flush_nostart"); pin(20, W_BUSY, 0, "flush_still_idle");
    pin(22, W_START, 0, "flush_never");
    step(); nop();
    repeat (19) begin step(); flush = 1'b1; put(OP_FP, F5_ADD, 3'b000, 5'd9, 5'd10, 5'd11, 0, 0); end
    step(); flush = 1'b0; nop(); repeat (3) step();

    // Reset mid-FDIV, then FADD right after
    step(); put(OP_FP, F5_DIV, 3'b000, 5'd3, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(5, W_BUSY, 1, "pre_rst_busy"); pin(6, W_BUSY, 0, "rst_busy");
    pin(6, W_WB, 0, "rst_wb");        pin(6, W_SEL, 0, "rst_sel");
    pin(6, W_WBRD, 0, "rst_wbrd");    pin(6, W_RDY, 1, "rst_accept");
    pin(7, W_START, 1, "rst_add_start"); pin(7, W_SEL, 8'd1, "rst_add_sel");
    pin(8, W_WB, 1, "rst_add_wb");    pin(8, W_WBRD, 4, "rst_add_wbrd");
    pin(9, W_BUSY, 0, "rst_add_idle"); pin(12, W_WB, 0, "rst_no_stale_wb");
    repeat (4) begin step(); nop(); end
    step(); reset = 1'b1; nop();
    step(); reset = 1'b0; put(OP_FP, F5_ADD, 3'b000, 5'd4, 5'd5, 5'd6, 0, 0);
    step(); nop(); repeat (6) step();

    // FADD f4 pending: integer use of x4 free, FLW f4 blocked until retire
    step(); put(OP_FP, F5_ADD, 3'b000, 5'd4, 5'd1, 5'd2, 0, 0); t0 = cyc;
    pin(1, W_RDY, 1, "int_x4_free"); pin(2, W_RDY, 0, "flw_waw_wb");
    pin(2, W_WB, 1, "flw_add_wb");   pin(3, W_RDY, 1, "flw_accept");
    step(); put(OPI, 5'd0, 3'd0, 5'd9, 5'd4, 5'd0, 1, 0);
    step(); put(OP_FLW, 5'd0, 3'b010, 5'd4, 5'd1, 5'd0, 0, 0);
    step(); put(OP_FLW, 5'd0, 3'b010, 5'd4, 5'd1, 5'd0, 0, 0);
    step(); nop(); repeat (2) step();

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
